// File: rtl/generic_reg_slave_pkg.sv
// Shared NF2 register-bus defines plus the types and helpers used by generic_reg_slave.
`ifndef NF2_DEFINES
`define NF2_DEFINES
`define CPCI_NF2_DATA_WIDTH 32
`define NF2_UNMAPPED_RD_DATA 32'hdead_beef
`endif

package generic_reg_slave_pkg;

  localparam int DATA_W = `CPCI_NF2_DATA_WIDTH;
  localparam logic [DATA_W-1:0] UNMAPPED_RD_DATA = `NF2_UNMAPPED_RD_DATA;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_DRAIN
  } state_t;

  // Bits needed to index 'value' entries; never less than 1 so single-entry banks still get a port.
  function automatic int log2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/reg_counter_bank.sv
// Bank of wrapping event counters with a single indexed clear port used for clear-on-read.
module reg_counter_bank #(
  parameter int NUM_COUNTERS  = 4,
  parameter int COUNTER_WIDTH = 32,
  parameter int IDX_W         = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_COUNTERS-1:0]               inc,
  input  logic                                  clear,
  input  logic [IDX_W-1:0]                      clear_idx,
  output logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] count
);

  for (genvar gi = 0; gi < NUM_COUNTERS; gi++) begin : g_cnt
    logic [COUNTER_WIDTH-1:0] cnt;

    // A clear coinciding with an increment keeps the increment, so no event is lost.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt <= '0;
      end else if (clear && (clear_idx == IDX_W'(gi))) begin
        cnt <= COUNTER_WIDTH'(inc[gi]);
      end else begin
        cnt <= cnt + COUNTER_WIDTH'(inc[gi]);
      end
    end

    assign count[gi*COUNTER_WIDTH +: COUNTER_WIDTH] = cnt;
  end

endmodule

// File: rtl/generic_reg_slave.sv
// Leaf responder on the NF2 register req/ack bus: event counters plus software R/W registers.
module generic_reg_slave
  import generic_reg_slave_pkg::*;
#(
  parameter int REG_ADDR_BITS = 8,
  parameter int NUM_COUNTERS  = 4,
  parameter int NUM_SW_REGS   = 4,
  parameter int COUNTER_WIDTH = 32,
  parameter int RESET_ON_READ = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            reg_req,
  input  logic                            reg_rd_wr_L,
  input  logic [REG_ADDR_BITS-1:0]        reg_addr,
  input  logic [DATA_W-1:0]               reg_wr_data,
  output logic                            reg_ack,
  output logic [DATA_W-1:0]               reg_rd_data,
  input  logic [NUM_COUNTERS-1:0]         counter_inc,
  output logic [NUM_SW_REGS*DATA_W-1:0]   sw_regs
);

  localparam int CNT_IDX_W = log2(NUM_COUNTERS);
  localparam int SW_IDX_W  = log2(NUM_SW_REGS);

  state_t state, state_next;
  logic   access;

  logic [31:0]          addr_w;
  logic                 is_cnt, is_sw;
  logic [CNT_IDX_W-1:0] cnt_idx;
  logic [SW_IDX_W-1:0]  sw_idx;
  logic [DATA_W-1:0]    rd_mux;
  logic                 cnt_clear;

  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] cnt_flat;
  logic [COUNTER_WIDTH-1:0]              cnt_arr [NUM_COUNTERS];
  logic [DATA_W-1:0]                     sw_arr  [NUM_SW_REGS];

  always_comb begin
    state_next = state;
    reg_ack    = 1'b0;
    access     = 1'b0;
    case (state)
      ST_IDLE: begin
        access = reg_req;
        if (reg_req) state_next = ST_ACK;
      end
      ST_ACK: begin
        reg_ack = 1'b1;
        if (!reg_req) state_next = ST_IDLE;
      end
      ST_DRAIN: begin
        if (!reg_req) state_next = ST_IDLE;
      end
      default: state_next = ST_DRAIN;
    endcase
  end

  // Reset parks in DRAIN so a request left high across reset is never served.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_DRAIN;
    else       state <= state_next;
  end

  assign addr_w  = 32'(reg_addr);
  assign is_cnt  = addr_w < 32'(NUM_COUNTERS);
  assign is_sw   = !is_cnt && (addr_w < 32'(NUM_COUNTERS + NUM_SW_REGS));
  assign cnt_idx = CNT_IDX_W'(addr_w);
  assign sw_idx  = SW_IDX_W'(addr_w - 32'(NUM_COUNTERS));

  assign cnt_clear = access && reg_rd_wr_L && is_cnt && (RESET_ON_READ != 0);

  reg_counter_bank #(
    .NUM_COUNTERS (NUM_COUNTERS),
    .COUNTER_WIDTH(COUNTER_WIDTH),
    .IDX_W        (CNT_IDX_W)
  ) u_counters (
    .clk      (clk),
    .reset    (reset),
    .inc      (counter_inc),
    .clear    (cnt_clear),
    .clear_idx(cnt_idx),
    .count    (cnt_flat)
  );

  for (genvar gi = 0; gi < NUM_COUNTERS; gi++) begin : g_cnt_unpack
    assign cnt_arr[gi] = cnt_flat[gi*COUNTER_WIDTH +: COUNTER_WIDTH];
  end

  // Counter values are sampled before this edge's increment lands.
  always_comb begin
    rd_mux = UNMAPPED_RD_DATA;
    if (is_cnt)     rd_mux = DATA_W'(cnt_arr[cnt_idx]);
    else if (is_sw) rd_mux = sw_arr[sw_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_rd_data <= '0;
    end else if (access) begin
      reg_rd_data <= reg_rd_wr_L ? rd_mux : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SW_REGS; i++) sw_arr[i] <= '0;
    end else if (access && !reg_rd_wr_L && is_sw) begin
      sw_arr[sw_idx] <= reg_wr_data;
    end
  end

  for (genvar gi = 0; gi < NUM_SW_REGS; gi++) begin : g_sw_pack
    assign sw_regs[gi*DATA_W +: DATA_W] = sw_arr[gi];
  end

endmodule

// File: tb/tb_generic_reg_slave.sv
// Drives three generic_reg_slave variants in lockstep and compares them against a transaction-level model.
module tb_generic_reg_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req;
  logic        rd_wr_L;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  inc;

  logic         ack [3];
  logic [31:0]  rd  [3];
  logic [127:0] sw  [3];

  generic_reg_slave u0 (
    .clk(clk), .reset(reset), .reg_req(req), .reg_rd_wr_L(rd_wr_L), .reg_addr(addr),
    .reg_wr_data(wdata), .reg_ack(ack[0]), .reg_rd_data(rd[0]), .counter_inc(inc), .sw_regs(sw[0])
  );

  generic_reg_slave #(.RESET_ON_READ(1)) u1 (
    .clk(clk), .reset(reset), .reg_req(req), .reg_rd_wr_L(rd_wr_L), .reg_addr(addr),
    .reg_wr_data(wdata), .reg_ack(ack[1]), .reg_rd_data(rd[1]), .counter_inc(inc), .sw_regs(sw[1])
  );

  generic_reg_slave #(.COUNTER_WIDTH(8)) u2 (
    .clk(clk), .reset(reset), .reg_req(req), .reg_rd_wr_L(rd_wr_L), .reg_addr(addr),
    .reg_wr_data(wdata), .reg_ack(ack[2]), .reg_rd_data(rd[2]), .counter_inc(inc), .sw_regs(sw[2])
  );

  int checks = 0;
  int errors = 0;

  longint unsigned mcnt [3][4];
  logic [31:0]     msw  [3][4];
  logic [31:0]     mrd  [3];
  int              cwid [3] = '{32, 32, 8};
  bit              ror  [3] = '{1'b0, 1'b1, 1'b0};
  bit              rnd_inc;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mread(input int d, input int a);
    if (a < 4)      return 32'(mcnt[d][a]);
    else if (a < 8) return msw[d][a-4];
    else            return 32'hdead_beef;
  endfunction

  function automatic logic [3:0] ninc();
    return rnd_inc ? 4'($urandom_range(0, 15)) : 4'b0000;
  endfunction

  // One clock edge: update the model as the spec's rules dictate, then advance to the next negedge.
  task automatic step(input logic [3:0] inc_v, input bit acc);
    int a;
    a = int'(addr);
    for (int d = 0; d < 3; d++) begin
      if (acc) begin
        mrd[d] = rd_wr_L ? mread(d, a) : 32'h0;
        if (!rd_wr_L && a >= 4 && a < 8) msw[d][a-4] = wdata;
      end
      for (int i = 0; i < 4; i++) begin
        if (acc && rd_wr_L && a == i && ror[d]) mcnt[d][i] = longint'(inc_v[i]);
        else mcnt[d][i] = (mcnt[d][i] + longint'(inc_v[i])) % (64'd1 << cwid[d]);
      end
    end
    inc = inc_v;
    @(posedge clk);
    @(negedge clk);
    inc = 4'b0000;
  endtask

  task automatic check_sw(input string tag);
    logic [127:0] e;
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 4; i++) e[i*32 +: 32] = msw[d][i];
      check($sformatf("%s_sw%0d", tag, d), sw[d], e);
    end
  endtask

  task automatic check_acked(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_ack%0d", tag, d), 128'(ack[d]), 128'(1'b1));
      check($sformatf("%s_rd%0d", tag, d), 128'(rd[d]), 128'(mrd[d]));
    end
    check_sw(tag);
  endtask

  task automatic check_noack(input string tag);
    for (int d = 0; d < 3; d++)
      check($sformatf("%s_ack%0d", tag, d), 128'(ack[d]), 128'(1'b0));
  endtask

  task automatic xact(input bit rdop, input int a, input logic [31:0] wd, input int hold,
                      input logic [3:0] acc_inc, input string tag);
    req     = 1'b1;
    rd_wr_L = rdop;
    addr    = 8'(a);
    wdata   = wd;
    step(acc_inc, 1'b1);
    check_acked(tag);
    for (int h = 1; h < hold; h++) begin
      addr    = 8'($urandom);
      wdata   = $urandom;
      rd_wr_L = 1'($urandom_range(0, 1));
      step(ninc(), 1'b0);
      check_acked($sformatf("%s_h%0d", tag, h));
    end
    req = 1'b0;
    check_acked({tag, "_ovl"});
    step(ninc(), 1'b0);
    check_noack({tag, "_end"});
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    inc   = 4'b0000;
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 4; i++) begin
        mcnt[d][i] = 0;
        msw[d][i]  = 32'h0;
      end
      mrd[d] = 32'h0;
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_ack%0d", tag, d), 128'(ack[d]), 128'(1'b0));
      check($sformatf("%s_rd%0d", tag, d), 128'(rd[d]), 128'(32'h0));
    end
    check_sw(tag);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    req     = 1'b0;
    rd_wr_L = 1'b1;
    addr    = 8'h00;
    wdata   = 32'h0;
    inc     = 4'b0000;
    rnd_inc = 1'b0;
    @(negedge clk);
    do_reset("rst");
    step(4'b0000, 1'b0);

    xact(1'b1, 0, 32'h0, 3, 4'b0000, "rd0");
    xact(1'b0, 5, 32'h1234_5678, 1, 4'b0000, "wr5");
    xact(1'b1, 5, 32'h0, 1, 4'b0000, "rb5");

    for (int k = 0; k < 5; k++) step(4'b0100, 1'b0);
    xact(1'b1, 2, 32'h0, 1, 4'b0000, "cnt2a");
    xact(1'b1, 2, 32'h0, 1, 4'b0000, "cnt2b");

    do_reset("rst2");
    step(4'b0000, 1'b0);
    for (int k = 0; k < 7; k++) step(4'b0010, 1'b0);
    xact(1'b1, 1, 32'h0, 1, 4'b0010, "cor_a");
    xact(1'b1, 1, 32'h0, 1, 4'b0000, "cor_b");

    xact(1'b1, 9, 32'h0, 2, 4'b0000, "unm_rd");
    xact(1'b0, 200, 32'hcafe_f00d, 1, 4'b0000, "unm_wr");
    xact(1'b0, 0, 32'h5555_aaaa, 1, 4'b0000, "wr_cnt0");
    xact(1'b1, 0, 32'h0, 1, 4'b0000, "rd_cnt0");

    req     = 1'b1;
    rd_wr_L = 1'b1;
    addr    = 8'd4;
    step(4'b0000, 1'b1);
    check_acked("pre_rst");
    do_reset("rst_ack");
    for (int k = 0; k < 3; k++) begin
      step(4'b0000, 1'b0);
      check_noack($sformatf("drain%0d", k));
    end
    req = 1'b0;
    step(4'b0000, 1'b0);
    check_noack("drain_rel");
    xact(1'b1, 4, 32'h0, 1, 4'b0000, "post_drain");

    do_reset("rst3");
    step(4'b0000, 1'b0);
    for (int k = 0; k < 256; k++) step(4'b1000, 1'b0);
    xact(1'b1, 3, 32'h0, 1, 4'b0000, "wrap");

    rnd_inc = 1'b1;
    for (int t = 0; t < 40; t++) begin
      xact(1'($urandom_range(0, 1)), int'($urandom_range(0, 11)), $urandom,
           int'($urandom_range(1, 3)), ninc(), $sformatf("rnd%0d", t));
      if ($urandom_range(0, 1) == 1) step(ninc(), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
